// File: rtl/apb_master_bridge_pkg.sv
// Shared widths, FSM state encoding and timeout counter sizing for the APB master bridge.
package apb_master_bridge_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        APB_M_IDLE   = 2'd0,
        APB_M_SETUP  = 2'd1,
        APB_M_ACCESS = 2'd2,
        APB_M_RESP   = 2'd3
    } apb_m_state_e;

    // The counter must be able to hold the terminal value itself; a disabled timeout still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t == 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response channel plus APB bus, bundled for the bridge (master) and its surroundings (slave).
interface apb_master_bridge_if;
    import apb_master_bridge_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_wr;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [APB_DATA_WIDTH-1:0] req_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata;
    logic                      rsp_err;
    logic                      apb_psel;
    logic                      apb_enab;
    logic                      apb_rw;
    logic [ADDR_WIDTH-1:0]     apb_addr;
    logic [APB_DATA_WIDTH-1:0] apb_wdata;
    logic [APB_DATA_WIDTH-1:0] apb_rdata;
    logic                      apb_ack;

    modport master (
        input  req_valid, req_wr, req_addr, req_wdata, rsp_ready, apb_rdata, apb_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               apb_psel, apb_enab, apb_rw, apb_addr, apb_wdata
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_wdata, rsp_ready, apb_rdata, apb_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               apb_psel, apb_enab, apb_rw, apb_addr, apb_wdata
    );

endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: one outstanding valid/ready request turned into SETUP/ACCESS, with ACCESS timeout.
//   state  | meaning
//   IDLE   | req_ready high, waiting for a request
//   SETUP  | psel high, enab low, address/control driven
//   ACCESS | psel+enab high, waiting for apb_ack or timeout
//   RESP   | rsp_valid held until rsp_ready
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    apb_master_bridge_if.master  bus
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

    apb_m_state_e              state_q;
    logic                      req_ready_q;
    logic                      rsp_valid_q;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
    logic                      rsp_err_q;
    logic                      psel_q;
    logic                      enab_q;
    logic                      rw_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic                      timeout_hit;

    assign cnt_d       = cnt_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= APB_M_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            enab_q      <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                APB_M_IDLE: begin
                    // req_ready_q is low only in the first cycle after reset release
                    if (req_ready_q && bus.req_valid) begin
                        req_ready_q <= 1'b0;
                        rw_q        <= bus.req_wr;
                        addr_q      <= bus.req_addr;
                        wdata_q     <= bus.req_wdata;
                        psel_q      <= 1'b1;
                        enab_q      <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= APB_M_SETUP;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                APB_M_SETUP: begin
                    enab_q  <= 1'b1;
                    state_q <= APB_M_ACCESS;
                end
                APB_M_ACCESS: begin
                    if (bus.apb_ack) begin
                        rsp_rdata_q <= rw_q ? '0 : bus.apb_rdata;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        enab_q      <= 1'b0;
                        state_q     <= APB_M_RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        psel_q      <= 1'b0;
                        enab_q      <= 1'b0;
                        state_q     <= APB_M_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                APB_M_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= APB_M_IDLE;
                    end
                end
                default: state_q <= APB_M_IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.apb_psel  = psel_q;
    assign bus.apb_enab  = enab_q;
    assign bus.apb_rw    = rw_q;
    assign bus.apb_addr  = addr_q;
    assign bus.apb_wdata = wdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: one task per scenario, inputs driven and outputs sampled on negedge.
module tb_apb_master_bridge;
    import apb_master_bridge_pkg::*;

    logic clk;
    logic resetn;
    int   n_checks;
    int   n_fail;

    apb_master_bridge_if bus ();

    apb_master_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a request from a negedge and returns at the negedge of the SETUP cycle (cycle 1).
    task automatic accept_req(input logic wr, input logic [ADDR_WIDTH-1:0] addr,
                              input logic [APB_DATA_WIDTH-1:0] wdata);
        bit ok;
        ok            = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b, required 1 within 20 cycles", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn        = 1'b0;
        bus.req_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.apb_psel,
             bus.apb_enab, bus.apb_rw, bus.apb_addr, bus.apb_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b rvalid=%b psel=%b enab=%b addr=%h, required all 0",
                     bus.req_ready, bus.rsp_valid, bus.apb_psel, bus.apb_enab, bus.apb_addr);
        end
        bus.req_valid = 1'b0;
        resetn        = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.apb_psel, bus.rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release: ready/psel/rvalid=%b, required 100",
                     {bus.req_ready, bus.apb_psel, bus.rsp_valid});
        end
    endtask

    task automatic test_write();
        accept_req(1'b1, 32'h08, 32'hDEADBEEF);
        n_checks++;
        if ({bus.apb_psel, bus.apb_enab, bus.apb_rw, bus.apb_addr, bus.apb_wdata, bus.req_ready}
            !== {1'b1, 1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL write_setup: psel=%b enab=%b rw=%b addr=%h wdata=%h ready=%b, required 1 0 1 08 deadbeef 0",
                     bus.apb_psel, bus.apb_enab, bus.apb_rw, bus.apb_addr, bus.apb_wdata, bus.req_ready);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.apb_psel, bus.apb_enab, bus.apb_rw, bus.apb_addr, bus.apb_wdata, bus.rsp_valid}
            !== {1'b1, 1'b1, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL write_access: psel=%b enab=%b rw=%b addr=%h wdata=%h rvalid=%b, required 1 1 1 08 deadbeef 0",
                     bus.apb_psel, bus.apb_enab, bus.apb_rw, bus.apb_addr, bus.apb_wdata, bus.rsp_valid);
        end
        bus.apb_ack   = 1'b1;
        bus.apb_rdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.apb_ack = 1'b0;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.apb_psel, bus.apb_enab}
            !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL write_rsp: rvalid=%b err=%b rdata=%h psel=%b enab=%b, required 1 0 00000000 0 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.apb_psel, bus.apb_enab);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL write_idle: rvalid/ready=%b, required 01", {bus.rsp_valid, bus.req_ready});
        end
    endtask

    task automatic test_read();
        accept_req(1'b0, 32'h0C, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({bus.apb_psel, bus.apb_enab, bus.apb_rw, bus.apb_addr} !== {1'b1, 1'b1, 1'b0, 32'h0C}) begin
            n_fail++;
            $display("FAIL read_access: psel=%b enab=%b rw=%b addr=%h, required 1 1 0 0000000c",
                     bus.apb_psel, bus.apb_enab, bus.apb_rw, bus.apb_addr);
        end
        bus.apb_ack   = 1'b1;
        bus.apb_rdata = 32'h12345678;
        @(negedge clk);
        bus.apb_ack   = 1'b0;
        bus.apb_rdata = 32'h0;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
            n_fail++;
            $display("FAIL read_rsp: rvalid=%b err=%b rdata=%h, required 1 0 12345678",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        int  enab_cycles;
        bit  stable;
        enab_cycles = 0;
        stable      = 1'b1;
        accept_req(1'b0, 32'h10, 32'h0);
        for (int cyc = 2; cyc <= 5; cyc++) begin
            @(negedge clk);
            if (bus.apb_enab === 1'b1) enab_cycles++;
            if ({bus.apb_psel, bus.apb_rw, bus.apb_addr, bus.rsp_valid} !== {1'b1, 1'b0, 32'h10, 1'b0})
                stable = 1'b0;
            if (cyc == 5) begin
                bus.apb_ack   = 1'b1;
                bus.apb_rdata = 32'hA5A50001;
            end
        end
        @(negedge clk);
        bus.apb_ack = 1'b0;
        n_checks++;
        if (enab_cycles != 4 || !stable) begin
            n_fail++;
            $display("FAIL wait_access: enab cycles=%0d stable=%b, required 4 and 1", enab_cycles, stable);
        end
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'hA5A50001}) begin
            n_fail++;
            $display("FAIL wait_rsp_cycle6: rvalid=%b err=%b rdata=%h, required 1 0 a5a50001",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        @(negedge clk);
    endtask

    // late_ack: assert apb_ack in cycle 18, the same cycle the counter expires.
    task automatic test_timeout(input bit late_ack);
        int got;
        got           = -1;
        bus.apb_rdata = 32'h77778888;
        accept_req(1'b0, 32'h20, 32'h0);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.rsp_valid === 1'b1) begin
                got = cyc;
                break;
            end
            if (late_ack && cyc == 18) bus.apb_ack = 1'b1;
            @(negedge clk);
        end
        bus.apb_ack = 1'b0;
        n_checks++;
        if (got != 19) begin
            n_fail++;
            $display("FAIL timeout_latency(late_ack=%0d): rsp cycle=%0d, required 19", late_ack, got);
        end
        n_checks++;
        if (late_ack) begin
            if ({bus.rsp_err, bus.rsp_rdata, bus.apb_psel} !== {1'b0, 32'h77778888, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout_ack_wins: err=%b rdata=%h psel=%b, required 0 77778888 0",
                         bus.rsp_err, bus.rsp_rdata, bus.apb_psel);
            end
        end else begin
            if ({bus.rsp_err, bus.rsp_rdata, bus.apb_psel, bus.apb_enab} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL timeout_err: err=%b rdata=%h psel=%b enab=%b, required 1 00000000 0 0",
                         bus.rsp_err, bus.rsp_rdata, bus.apb_psel, bus.apb_enab);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({bus.apb_psel, bus.rsp_valid, bus.req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL timeout_after: psel/rvalid/ready=%b, required 001",
                     {bus.apb_psel, bus.rsp_valid, bus.req_ready});
        end
        bus.apb_rdata = 32'h0;
    endtask

    task automatic test_backpressure();
        bit held;
        held          = 1'b1;
        bus.rsp_ready = 1'b0;
        accept_req(1'b0, 32'h34, 32'h0);
        @(negedge clk);
        bus.apb_ack   = 1'b1;
        bus.apb_rdata = 32'h0BADF00D;
        @(negedge clk);
        bus.apb_ack   = 1'b0;
        bus.apb_rdata = 32'h0;
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_addr  = 32'h38;
        bus.req_wdata = 32'h00000077;
        for (int cyc = 3; cyc <= 7; cyc++) begin
            if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready, bus.apb_psel}
                !== {1'b1, 1'b0, 32'h0BADF00D, 1'b0, 1'b0})
                held = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!held) begin
            n_fail++;
            $display("FAIL bp_hold: rvalid=%b rdata=%h ready=%b psel=%b, required 1 0badf00d 0 0 over 5 cycles",
                     bus.rsp_valid, bus.rsp_rdata, bus.req_ready, bus.apb_psel);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.rsp_valid, bus.req_ready, bus.apb_psel} !== 3'b010) begin
            n_fail++;
            $display("FAIL bp_idle: rvalid/ready/psel=%b, required 010",
                     {bus.rsp_valid, bus.req_ready, bus.apb_psel});
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        n_checks++;
        if ({bus.apb_psel, bus.apb_enab, bus.apb_rw, bus.apb_addr, bus.apb_wdata}
            !== {1'b1, 1'b0, 1'b1, 32'h38, 32'h00000077}) begin
            n_fail++;
            $display("FAIL bp_second_setup: psel=%b enab=%b rw=%b addr=%h wdata=%h, required 1 0 1 00000038 00000077",
                     bus.apb_psel, bus.apb_enab, bus.apb_rw, bus.apb_addr, bus.apb_wdata);
        end
        @(negedge clk);
        bus.apb_ack = 1'b1;
        @(negedge clk);
        bus.apb_ack = 1'b0;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL bp_second_rsp: rvalid=%b err=%b rdata=%h, required 1 0 00000000",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_ack_idle();
        bit quiet;
        quiet       = 1'b1;
        bus.apb_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if ({bus.apb_psel, bus.apb_enab, bus.rsp_valid} !== 3'b000) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL ack_idle_quiet: psel/enab/rvalid=%b, required 000",
                     {bus.apb_psel, bus.apb_enab, bus.rsp_valid});
        end
        accept_req(1'b1, 32'h40, 32'h11223344);
        n_checks++;
        if ({bus.apb_psel, bus.apb_enab, bus.rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL ack_setup_ignored: psel/enab/rvalid=%b, required 100",
                     {bus.apb_psel, bus.apb_enab, bus.rsp_valid});
        end
        @(negedge clk);
        @(negedge clk);
        bus.apb_ack = 1'b0;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL ack_held_rsp: rvalid/err=%b, required 10", {bus.rsp_valid, bus.rsp_err});
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        accept_req(1'b0, 32'h50, 32'h0);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.apb_psel,
             bus.apb_enab, bus.apb_rw, bus.apb_addr, bus.apb_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: ready=%b rvalid=%b psel=%b enab=%b addr=%h, required all 0",
                     bus.req_ready, bus.rsp_valid, bus.apb_psel, bus.apb_enab, bus.apb_addr);
        end
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.apb_psel} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid_release: ready/rvalid/psel=%b, required 100",
                     {bus.req_ready, bus.rsp_valid, bus.apb_psel});
        end
        accept_req(1'b0, 32'h54, 32'h0);
        @(negedge clk);
        bus.apb_ack   = 1'b1;
        bus.apb_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        bus.apb_ack   = 1'b0;
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== {1'b1, 1'b0, 32'h5A5A5A5A}) begin
            n_fail++;
            $display("FAIL reset_mid_fresh: rvalid=%b err=%b rdata=%h, required 1 0 5a5a5a5a",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        resetn        = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        bus.apb_rdata = '0;
        bus.apb_ack   = 1'b0;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_backpressure();
        test_ack_idle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
